// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE
  } loader_state_t;

  localparam logic [1:0] LD_OK       = 2'd0;
  localparam logic [1:0] LD_ERR_CSUM = 2'd1;
  localparam logic [1:0] LD_ERR_LEN  = 2'd2;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words and keeps a running XOR.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [7:0]  csum,
  output logic        word_full
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    if (clear) begin
      byte_idx_d = '0;
      word_d     = '0;
      csum_d     = '0;
    end else if (byte_valid) begin
      word_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
      byte_idx_d = byte_idx_q + 2'd1;
      csum_d     = csum_q ^ byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
    end
  end

  // Asserted in the cycle whose accepted byte completes the word.
  assign word_full = byte_valid && !clear && (byte_idx_q == 2'd3);
  assign word      = word_q;
  assign csum      = csum_q;

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader writing words into instruction memory while holding the core.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS) + 1;

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       err_q, err_d;

  logic        asm_clear;
  logic        asm_valid;
  logic [31:0] asm_word;
  logic [7:0]  asm_csum;
  logic        asm_word_full;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (in_data),
    .word       (asm_word),
    .csum       (asm_csum),
    .word_full  (asm_word_full)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    err_d      = err_q;
    asm_clear  = 1'b0;
    asm_valid  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_HDR;
          count_d    = '0;
          word_idx_d = '0;
          err_d      = LD_OK;
          asm_clear  = 1'b1;
        end
      end
      ST_HDR: begin
        if (in_valid) begin
          if (in_data == 8'd0) begin
            state_d = ST_CHK;
          end else if (in_data > 8'(DEPTH_WORDS)) begin
            state_d = ST_DONE;
            err_d   = LD_ERR_LEN;
          end else begin
            count_d = IDX_W'(in_data);
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        asm_valid = in_valid;
        if (asm_word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        state_d    = (word_idx_d == count_q) ? ST_CHK : ST_DATA;
      end
      ST_CHK: begin
        if (in_valid) begin
          err_d   = (in_data == asm_csum) ? LD_OK : LD_ERR_CSUM;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      err_q      <= LD_OK;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      err_q      <= err_d;
    end
  end

  // Every output is a decode of registered state, so in_ready never depends on in_valid.
  assign in_ready  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = ADDR_W'({word_idx_q, 2'b00});
  assign mem_wdata = asm_word;
  assign busy      = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                     (state_q == ST_WRITE) || (state_q == ST_CHK);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign cpu_hold  = busy || (done && (err_q != LD_OK));

endmodule
